huc_sys_map: RTL and testbench
==============================

Name: huc_sys_map

Overview:
- Parametrised successor to the fixed-window menu mapper for the HuCard slot.
- Splits the CPU ROM region into NUM_WIN 8 KB windows, each backed by a CPU-writable bank register.
- Maps the upper half of the address space to save RAM, guarded by a two-write unlock sequence.
- Exposes a control page for bank/status readback.
- Sits inside the huc_sys wrapper and drives the rom/ram memory controls and cart_ce/cart_dato.

Parameters:
- ROM_AW, 22: ROM byte-address width. Bank width BW = ROM_AW-14, which must be ≤ 8.
- RAM_AW, 17: save-RAM byte-address width.
- NUM_WIN, 4: number of ROM windows. Power of 2, range 1..16.
- ROM_CHIP, 0: value driven on rom_addr MSB (PSR1 select).
- BANK_RST, 8'hFC: reset value of bank[0]. bank[i] resets to BANK_RST+i, truncated to BW.
- REG_PAGE, 8'hFF: value of cpu_addr[20:13] that selects the control page.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  21  CPU address (synchronous to clk)
- cpu_data  in  8  CPU write data
- cpu_ce  in  1  CPU cycle strobe
- cpu_oe  in  1  CPU read strobe
- cpu_we  in  1  CPU write strobe
- rom_addr  out  ROM_AW  ROM address
- rom_ce  out  1  ROM select
- rom_oe  out  1  ROM read enable
- rom_we  out  1  ROM write enable (tied 0)
- ram_addr  out  RAM_AW  RAM address
- ram_ce  out  1  RAM select
- ram_oe  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- mem_dati  out  8  write data to memories (= cpu_data)
- rom_dato  in  8  ROM read data
- ram_dato  in  8  RAM read data
- cart_ce  out  1  cart drives the bus
- cart_dato  out  8  cart read data

Behaviour:
- **Region decode** (combinational):
  - ROM when cpu_addr[20]==0.
  - Control page (REG) when cpu_addr[20:13]==REG_PAGE.
  - RAM otherwise.
- **ROM path:**
  - w = cpu_addr[13 +: log2(NUM_WIN)].
  - rom_addr = {ROM_CHIP, bank[w], cpu_addr[12:0]}.
  - rom_ce = ROM region; rom_oe = cpu_oe; rom_we = 0.
- **RAM path:**
  - ram_addr = cpu_addr[RAM_AW-1:0]; ram_ce = RAM region; ram_oe = cpu_oe.
  - ram_we = cpu_we & ram_ce & (fsm==OPEN).
- **Bus outputs:**
  - cart_ce = rom_ce | ram_ce | reg_sel.
  - cart_dato priority: ROM → rom_dato; REG → reg readback; else ram_dato.
- **Write event:** we_evt = cpu_ce & cpu_we & ~we_q, where we_q is the registered (cpu_ce & cpu_we). Exactly one event per CPU write, regardless of strobe length.
- **Register map** (REG page, offset cpu_addr[4:0]):
  - 0..NUM_WIN-1: bank[n], R/W, low BW bits. Readback is zero-extended.
  - 0x10: LOCK, W. Reads 0.
  - 0x11: STATUS, R = {6'b0, fsm==HALF, fsm==OPEN}.
  - Any other offset: writes ignored, reads 8'h00.
- **Bank update:** a write on we_evt takes effect on the next clk edge. The next CPU access uses the new mapping; the combinational path sees it one cycle after we_evt.
- **Unlock FSM** (states LOCKED, HALF, OPEN):
  - LOCKED: we_evt to LOCK with 8'h55 → HALF. Otherwise stay.
  - HALF: we_evt to LOCK with 8'hAA → OPEN. Any other we_evt (any address or data) → LOCKED.
  - OPEN: we_evt to LOCK with 8'h00 → LOCKED. All other writes, including RAM writes, stay OPEN.
- **Reset values:**
  - Asynchronous rst forces fsm=LOCKED, bank[i]=BANK_RST+i, we_q=0, at any time, including mid-sequence and mid-write.
  - rom_we and ram_we are 0 during reset.
  - Combinational outputs track inputs throughout.
- **Boundaries:**
  - RAM writes while LOCKED/HALF: ram_we stays 0; the read path is unaffected.
  - A write held across the reset release produces no event until the strobe drops and reasserts.
  - Bank values above the ROM size wrap naturally by truncation.

Decomposition:
- Package huc_map_pkg holds:
  - the LockState enum (LOCKED, HALF, OPEN);
  - register offsets REG_LOCK=5'h10 and REG_STAT=5'h11;
  - unlock key constants 8'h55, 8'hAA and 8'h00.
- One sub-module, huc_wr_edge: produces the single-cycle we_evt pulse plus latched addr/data.

Test Plan:
- Release reset; read cpu_addr 21'h02000 (NUM_WIN=4) → rom_addr = {0, 8'hFD, 13'h0000}; STATUS reads 8'h00.
- Write 8'h12 to REG offset 1, then read 21'h03ABC → rom_addr = {0, 8'h12, 13'h1ABC}; offset 1 reads back 8'h12.
- Write to RAM 21'h100010 while LOCKED → ram_we never asserts. Then write 55, AA to LOCK → STATUS = 8'h01; the RAM write now asserts ram_we with ram_addr = 17'h00010.
- Write 55, then a bank write, then AA → fsm returns to LOCKED after the bank write; STATUS = 8'h00.
- Hold cpu_we for 5 cycles on a bank write → exactly one we_evt. Assert rst while in HALF → LOCKED, banks reset to FC..FF.
- From OPEN, write 00 to LOCK → STATUS = 8'h00; subsequent RAM writes are blocked.

Source files
------------

// File: rtl/huc_map_pkg.sv
// Shared types and constants for the HuCard system mapper: unlock FSM states,
// control-page register offsets and the save-RAM unlock keys.
package huc_map_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        HALF   = 2'd1,
        OPEN   = 2'd2
    } LockState;

    localparam logic [4:0] REG_LOCK  = 5'h10;
    localparam logic [4:0] REG_STAT  = 5'h11;

    localparam logic [7:0] KEY_HALF  = 8'h55;
    localparam logic [7:0] KEY_OPEN  = 8'hAA;
    localparam logic [7:0] KEY_CLOSE = 8'h00;

endpackage

// File: rtl/huc_wr_edge.sv
// Turns a CPU write strobe of any length into a single-cycle event, and keeps
// the address/data of the most recent write available.
module huc_wr_edge (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [20:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_ce,
    input  logic        i_we,
    output logic        o_evt,
    output logic [20:0] o_addr,
    output logic [7:0]  o_data
);

    logic        w_strobe;
    logic        r_we_q;
    logic        r_armed;
    logic [20:0] r_addr;
    logic [7:0]  r_data;

    assign w_strobe = i_ce & i_we;
    // r_armed stays low until the strobe is seen idle, so a write held across
    // reset release cannot masquerade as a fresh event.
    assign o_evt    = w_strobe & ~r_we_q & r_armed;
    assign o_addr   = o_evt ? i_addr : r_addr;
    assign o_data   = o_evt ? i_data : r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we_q  <= 1'b0;
            r_armed <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_we_q <= w_strobe;
            if (!w_strobe) r_armed <= 1'b1;
            if (o_evt) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/huc_sys_map.sv
// HuCard system mapper: banked 8 KB ROM windows, key-guarded save RAM and a
// control page for bank and unlock-status readback.
module huc_sys_map
    import huc_map_pkg::*;
#(
    parameter int          ROM_AW   = 22,
    parameter int          RAM_AW   = 17,
    parameter int          NUM_WIN  = 4,
    parameter logic        ROM_CHIP = 1'b0,
    parameter logic [7:0]  BANK_RST = 8'hFC,
    parameter logic [7:0]  REG_PAGE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [20:0]       cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic              cpu_ce,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_ce,
    output logic              rom_oe,
    output logic              rom_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [7:0]        mem_dati,
    input  logic [7:0]        rom_dato,
    input  logic [7:0]        ram_dato,
    output logic              cart_ce,
    output logic [7:0]        cart_dato
);

    localparam int BW = ROM_AW - 14;
    localparam int WW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

    logic [BW-1:0] r_bank [NUM_WIN];
    LockState      r_state;
    LockState      w_state_nxt;

    logic          w_evt;
    logic [20:0]   w_evt_addr;
    logic [7:0]    w_evt_data;
    logic          w_evt_reg;
    logic          w_evt_lock;
    logic          w_rom;
    logic          w_reg;
    logic          w_ram;
    logic          w_open;
    logic          w_half;
    logic [WW-1:0] w_win;
    logic [4:0]    w_off;
    logic [7:0]    w_rd;

    huc_wr_edge u_wr_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_addr (cpu_addr),
        .i_data (cpu_data),
        .i_ce   (cpu_ce),
        .i_we   (cpu_we),
        .o_evt  (w_evt),
        .o_addr (w_evt_addr),
        .o_data (w_evt_data)
    );

    assign w_rom = ~cpu_addr[20];
    assign w_reg = (cpu_addr[20:13] == REG_PAGE);
    assign w_ram = cpu_addr[20] & ~w_reg;
    assign w_off = cpu_addr[4:0];
    assign w_win = (NUM_WIN > 1) ? cpu_addr[13 +: WW] : '0;

    assign w_evt_reg  = w_evt & (w_evt_addr[20:13] == REG_PAGE);
    assign w_evt_lock = w_evt_reg & (w_evt_addr[4:0] == REG_LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_WIN; i++) r_bank[i] <= BW'(BANK_RST + i);
        end else begin
            for (int unsigned i = 0; i < NUM_WIN; i++)
                if (w_evt_reg && (w_evt_addr[4:0] == 5'(i))) r_bank[i] <= w_evt_data[BW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LOCKED;
        else     r_state <= w_state_nxt;
    end

    // In HALF any write at all, not just a wrong key, aborts the sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOCKED: if (w_evt_lock && w_evt_data == KEY_HALF) w_state_nxt = HALF;
            HALF:   if (w_evt) w_state_nxt = (w_evt_lock && w_evt_data == KEY_OPEN) ? OPEN : LOCKED;
            OPEN:   if (w_evt_lock && w_evt_data == KEY_CLOSE) w_state_nxt = LOCKED;
            default: w_state_nxt = LOCKED;
        endcase
    end

    always_comb begin
        w_open = (r_state == OPEN);
        w_half = (r_state == HALF);
    end

    always_comb begin
        w_rd = '0;
        if (w_off == REG_STAT) w_rd = {6'b0, w_half, w_open};
        for (int unsigned i = 0; i < NUM_WIN; i++)
            if (w_off == 5'(i)) w_rd = 8'(r_bank[i]);
    end

    assign rom_addr  = {ROM_CHIP, r_bank[w_win], cpu_addr[12:0]};
    assign rom_ce    = w_rom;
    assign rom_oe    = cpu_oe;
    assign rom_we    = 1'b0;
    assign ram_addr  = cpu_addr[RAM_AW-1:0];
    assign ram_ce    = w_ram;
    assign ram_oe    = cpu_oe;
    assign ram_we    = cpu_we & w_ram & w_open;
    assign mem_dati  = cpu_data;
    assign cart_ce   = w_rom | w_ram | w_reg;
    assign cart_dato = w_rom ? rom_dato : (w_reg ? w_rd : ram_dato);

endmodule

// File: tb/tb_huc_sys_map.sv
// Directed bench for huc_sys_map: ROM banking, control page, unlock sequence,
// single-event write detection and reset behaviour.
module tb_huc_sys_map;

    logic        clk;
    logic        rst;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ce;
    logic        cpu_oe;
    logic        cpu_we;
    logic [21:0] rom_addr;
    logic        rom_ce;
    logic        rom_oe;
    logic        rom_we;
    logic [16:0] ram_addr;
    logic        ram_ce;
    logic        ram_oe;
    logic        ram_we;
    logic [7:0]  mem_dati;
    logic [7:0]  rom_dato;
    logic [7:0]  ram_dato;
    logic        cart_ce;
    logic [7:0]  cart_dato;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic        saw_we;
    logic [16:0] saw_ra;

    localparam logic [20:0] A_LOCK = 21'h1FE010;
    localparam logic [20:0] A_STAT = 21'h1FE011;
    localparam logic [20:0] A_RAM  = 21'h100010;

    huc_sys_map #(
        .ROM_AW   (22),
        .RAM_AW   (17),
        .NUM_WIN  (4),
        .ROM_CHIP (1'b0),
        .BANK_RST (8'hFC),
        .REG_PAGE (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_ce    (cpu_ce),
        .cpu_oe    (cpu_oe),
        .cpu_we    (cpu_we),
        .rom_addr  (rom_addr),
        .rom_ce    (rom_ce),
        .rom_oe    (rom_oe),
        .rom_we    (rom_we),
        .ram_addr  (ram_addr),
        .ram_ce    (ram_ce),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .mem_dati  (mem_dati),
        .rom_dato  (rom_dato),
        .ram_dato  (ram_dato),
        .cart_ce   (cart_ce),
        .cart_dato (cart_dato)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [20:0] a);
        cpu_addr = a;
        cpu_oe   = 1'b1;
        @(negedge clk);
    endtask

    // Drives one write, holding the strobe for 'hold' clock edges.
    task automatic wr(input logic [20:0] a, input logic [7:0] d, input int unsigned hold);
        tick();
        cpu_addr = a;
        cpu_data = d;
        cpu_oe   = 1'b0;
        cpu_ce   = 1'b1;
        cpu_we   = 1'b1;
        #1;
        saw_we = ram_we;
        saw_ra = ram_addr;
        repeat (hold) @(posedge clk);
        #1;
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        cpu_addr = A_RAM;
        cpu_data = 8'h00;
        cpu_ce   = 1'b1;
        cpu_we   = 1'b1;
        cpu_oe   = 1'b0;
        rom_dato = 8'hA5;
        ram_dato = 8'h3C;
        #1;
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_rom_we", rom_we, 0);
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();

        rd(21'h02000);
        check_eq("win1_rst_map", rom_addr, {1'b0, 8'hFD, 13'h0000});
        check_eq("win1_rom_ce", rom_ce, 1);
        check_eq("win1_ram_ce", ram_ce, 0);
        check_eq("win1_dato", cart_dato, 8'hA5);
        rd(21'h06000);
        check_eq("win3_rst_map", rom_addr, {1'b0, 8'hFF, 13'h0000});
        rd(A_STAT);
        check_eq("stat_rst", cart_dato, 8'h00);
        check_eq("reg_cart_ce", cart_ce, 1);
        check_eq("reg_rom_ce", rom_ce, 0);

        wr(21'h1FE001, 8'h12, 1);
        rd(21'h03ABC);
        check_eq("win1_new_map", rom_addr, {1'b0, 8'h12, 13'h1ABC});
        rd(21'h1FE001);
        check_eq("bank1_rb", cart_dato, 8'h12);
        wr(21'h1FE005, 8'h77, 1);
        rd(21'h1FE005);
        check_eq("undef_off_rb", cart_dato, 8'h00);

        wr(A_RAM, 8'h99, 1);
        check_eq("ram_we_locked", saw_we, 0);
        rd(A_RAM);
        check_eq("ram_rd_dato", cart_dato, 8'h3C);
        check_eq("ram_rd_ce", ram_ce, 1);
        check_eq("ram_rd_oe", ram_oe, 1);

        wr(A_LOCK, 8'h55, 1);
        rd(A_STAT);
        check_eq("stat_half", cart_dato, 8'h02);
        wr(A_LOCK, 8'hAA, 1);
        rd(A_STAT);
        check_eq("stat_open", cart_dato, 8'h01);
        rd(A_LOCK);
        check_eq("lock_rb_zero", cart_dato, 8'h00);
        wr(A_RAM, 8'h99, 1);
        check_eq("ram_we_open", saw_we, 1);
        check_eq("ram_addr_open", saw_ra, 17'h00010);

        wr(A_LOCK, 8'h00, 1);
        rd(A_STAT);
        check_eq("stat_closed", cart_dato, 8'h00);
        wr(A_RAM, 8'h99, 1);
        check_eq("ram_we_closed", saw_we, 0);

        wr(A_LOCK, 8'h55, 1);
        wr(21'h1FE002, 8'h34, 1);
        rd(A_STAT);
        check_eq("stat_abort", cart_dato, 8'h00);
        wr(A_LOCK, 8'hAA, 1);
        rd(A_STAT);
        check_eq("stat_aa_locked", cart_dato, 8'h00);
        rd(21'h1FE002);
        check_eq("bank2_rb", cart_dato, 8'h34);

        wr(A_LOCK, 8'h55, 5);
        rd(A_STAT);
        check_eq("stat_held_once", cart_dato, 8'h02);

        tick();
        rst = 1'b1;
        rd(A_STAT);
        check_eq("stat_rst_half", cart_dato, 8'h00);
        rd(21'h1FE000);
        check_eq("bank0_rst", cart_dato, 8'hFC);
        rd(21'h1FE001);
        check_eq("bank1_rst", cart_dato, 8'hFD);
        rd(21'h1FE002);
        check_eq("bank2_rst", cart_dato, 8'hFE);
        rd(21'h1FE003);
        check_eq("bank3_rst", cart_dato, 8'hFF);

        tick();
        cpu_addr = A_LOCK;
        cpu_data = 8'h55;
        cpu_oe   = 1'b0;
        cpu_ce   = 1'b1;
        cpu_we   = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        tick();
        rd(A_STAT);
        check_eq("stat_held_rst", cart_dato, 8'h00);
        wr(A_LOCK, 8'h55, 1);
        rd(A_STAT);
        check_eq("stat_after_rearm", cart_dato, 8'h02);
        check_eq("mem_dati", mem_dati, cpu_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
